fifo_ctrl: RTL
==============

# fifo_ctrl

Sequencing controller for the 8-entry × 10-bit transaction-layer memory. It turns requester `push`/`pop` strobes into the memory's `wr_en`, `rd_en`, `wr_ptr` and `rd_ptr`, and tracks occupancy with full/empty flags. It also provides programmable almost-full/almost-empty flags for upstream flow control and a sticky error state on overflow or underflow. It sits between the transaction-layer producers/consumers and the memory; it does not carry data.

## Interface
- `DEPTH`, 8, number of memory entries (power of two).
- `ADDR_W`, 3, pointer width, log2(DEPTH).
- `CNT_W`, 4, occupancy/threshold width, log2(DEPTH)+1.

- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `init`  in  1  while high in INIT/IDLE, the controller latches the thresholds.
- `th_high`  in  CNT_W  almost-full threshold, sampled during INIT.
- `th_low`  in  CNT_W  almost-empty threshold, sampled during INIT.
- `push`  in  1  write request for this cycle.
- `pop`  in  1  read request for this cycle.
- `wr_en`  out  1  memory write enable (combinational).
- `rd_en`  out  1  memory read enable (combinational).
- `wr_ptr`  out  ADDR_W  memory write address (registered).
- `rd_ptr`  out  ADDR_W  memory read address (registered).
- `count`  out  CNT_W  current occupancy, 0..DEPTH.
- `full`, `empty`, `almost_full`, `almost_empty`  out  1 each  status flags.
- `data_valid`  out  1  memory `data_out` is valid this cycle.
- `error`  out  1  sticky overflow/underflow indication.
- `state`  out  3  FSM state: RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4.

## Operation
- **Reset.** When `reset`=1 at a clock edge:
  - `state`=RESET, pointers=0, `count`=0.
  - Latched thresholds: `th_high_q`=DEPTH-1, `th_low_q`=1.
  - `data_valid`=0, `error`=0.
  - Resulting outputs: `empty`=1, `almost_empty`=1, `full`=0, `almost_full`=0, `wr_en`=`rd_en`=0.
  - Reset takes priority over every other event, including mid-transfer.
- **FSM transitions:**
  - RESET → INIT on the first edge with `reset`=0.
  - INIT: latches `th_high` (clamped to DEPTH) and `th_low` every cycle; → IDLE when `init`=0.
  - IDLE (`count`=0): `init`=1 → INIT. Accepted push → ACTIVE. Pop → ERROR (underflow).
  - ACTIVE: stays while `count`>0 after the update. → IDLE when the next `count`=0. Overflow or underflow → ERROR.
  - ERROR: `error`=1, `wr_en`=`rd_en`=0, pointers and count frozen. Leaves only on `reset`.
- Push and pop are honored only in IDLE and ACTIVE; they are ignored in RESET and INIT.
- `wr_en` = `push` & (IDLE|ACTIVE) & !`full`.
- `rd_en` = `pop` & ACTIVE & !`empty`.
- **Overflow:** `push` while `full` (regardless of `pop`) → ERROR at the next edge. No write occurs.
- **Underflow:** `pop` while `empty` (regardless of `push`; there is no bypass) → ERROR at the next edge.
- **Pointer and count updates:**
  - `wr_ptr` increments mod DEPTH on each write; `rd_ptr` increments mod DEPTH on each read. Natural ADDR_W wrap 7→0.
  - `count` += `wr_en` − `rd_en`; simultaneous write and read leave it unchanged.
  - `count` is kept in CNT_W bits, so full (8) is distinguishable from empty (0).
- **Flags** (combinational from registered `count` and thresholds):
  - `full` = (`count`==DEPTH); `empty` = (`count`==0).
  - `almost_full` = (`count` ≥ `th_high_q`); `almost_empty` = (`count` ≤ `th_low_q`).

## Timing
- Memory write occurs at the rising edge where `wr_en`=1, at the current `wr_ptr`. `wr_ptr` advances at that same edge.
- Read data appears on memory `data_out` one cycle after the `rd_en` edge. `data_valid` is `rd_en` registered one cycle, so it is aligned with that data.
- Flags and `count` reflect a push/pop in the cycle after the accepting edge.
- A push on a cycle where `full` is already 1 is an overflow, even if the same-cycle pop would free a slot.
- Thresholds change only in INIT. Flags use the new values from the cycle after latching.
- ERROR is visible on `state`/`error` one cycle after the offending request.

## Test plan
- **Reset.** Assert `reset` 2 cycles with `push`=`pop`=1 → `state`=0, `wr_ptr`=`rd_ptr`=0, `count`=0, `empty`=1, `almost_empty`=1, `wr_en`=`rd_en`=0, `error`=0.
- **Fill.** `init`=1 with `th_high`=6, `th_low`=2 for 1 cycle, then push 8 consecutive cycles.
  - `wr_ptr` steps 0..7 then wraps to 0; `count`=8; `full`=1 the cycle after the 8th push.
  - `almost_full`=1 the cycle after the 6th push; `almost_empty` drops after the 3rd push.
- **Drain.** Pop 8 cycles from full.
  - `data_valid`=1 exactly one cycle after each `rd_en`; `rd_ptr` steps 0..7 then wraps to 0.
  - `empty`=1 and `state`=IDLE after the last pop.
- **Simultaneous push/pop.** Push and pop together at `count`=3 → `wr_en`=`rd_en`=1, `count` stays 3, both pointers +1, `state` remains ACTIVE.
- **Error entry.** Push at `count`=8 → `wr_en`=0, next cycle `error`=1 and `state`=4. Further push/pop is ignored until `reset`. Separately, pop at `count`=0 in IDLE → `state`=4.
- **Reset mid-operation.** Assert `reset` at `count`=5 with the pointers wrapped → next cycle all reset values and thresholds 7/1; after release, `state` goes to INIT then IDLE.

Source files
------------

// File: rtl/fifo_ctrl.sv
// Sequencing controller for an 8-entry transaction-layer memory: turns push/pop
// strobes into write/read enables and pointers, with occupancy flags and a sticky error state.
module fifo_ctrl #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned CNT_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init,
  input  logic [CNT_W-1:0]  th_high,
  input  logic [CNT_W-1:0]  th_low,
  input  logic              push,
  input  logic              pop,
  output logic              wr_en,
  output logic              rd_en,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic [ADDR_W-1:0] rd_ptr,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              data_valid,
  output logic              error,
  output logic [2:0]        state
);

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_INIT   = 3'd1,
    S_IDLE   = 3'd2,
    S_ACTIVE = 3'd3,
    S_ERROR  = 3'd4
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  r_th_high;
  logic [CNT_W-1:0]  r_th_low;
  logic              r_data_valid;
  logic              r_error;

  logic              w_full;
  logic              w_empty;
  logic              w_accept;
  logic              w_wr;
  logic              w_rd;
  logic              w_overflow;
  logic              w_underflow;
  logic [CNT_W-1:0]  w_count_nxt;
  logic [CNT_W-1:0]  w_th_high_clamp;

  // Status and request qualification from registered occupancy
  assign w_full          = (r_count == CNT_W'(DEPTH));
  assign w_empty         = (r_count == '0);
  assign w_accept        = (r_state == S_IDLE) || (r_state == S_ACTIVE);
  assign w_wr            = push & w_accept & ~w_full;
  assign w_rd            = pop & (r_state == S_ACTIVE) & ~w_empty;
  assign w_overflow      = push & w_accept & w_full;
  assign w_underflow     = pop & w_accept & w_empty;
  assign w_count_nxt     = r_count + CNT_W'(w_wr) - CNT_W'(w_rd);
  assign w_th_high_clamp = (th_high > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : th_high;

  // Controller state, pointers, occupancy and latched thresholds
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_RESET;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_th_high    <= CNT_W'(DEPTH - 1);
      r_th_low     <= CNT_W'(1);
      r_data_valid <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_data_valid <= w_rd;
      case (r_state)
        S_RESET: r_state <= S_INIT;
        S_INIT: begin
          r_th_high <= w_th_high_clamp;
          r_th_low  <= th_low;
          if (!init) r_state <= S_IDLE;
        end
        S_IDLE, S_ACTIVE: begin
          if (w_overflow || w_underflow) begin
            r_state <= S_ERROR;
            r_error <= 1'b1;
          end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            if (w_rd) r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            r_count <= w_count_nxt;
            // A write in IDLE wins over a re-init request in the same cycle
            if (w_count_nxt != '0)
              r_state <= S_ACTIVE;
            else if ((r_state == S_IDLE) && init)
              r_state <= S_INIT;
            else
              r_state <= S_IDLE;
          end
        end
        S_ERROR: r_state <= S_ERROR;
        default: r_state <= S_RESET;
      endcase
    end
  end

  assign wr_en        = w_wr;
  assign rd_en        = w_rd;
  assign wr_ptr       = r_wr_ptr;
  assign rd_ptr       = r_rd_ptr;
  assign count        = r_count;
  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (r_count >= r_th_high);
  assign almost_empty = (r_count <= r_th_low);
  assign data_valid   = r_data_valid;
  assign error        = r_error;
  assign state        = r_state;

endmodule
